// File: rtl/alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : alu_sequencer
// Description : Command FIFO feeding a four-state sequencer.
//               The sequencer runs each command through an external
//               combinational ALU, and updates an 8-bit accumulator and a
//               carry flag. It then hands the result to a consumer using a
//               valid/ready handshake.
// Revision    : 1.0  initial release
// ============================================================================
module alu_sequencer #(
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [3:0] cmd_op,
    input  logic [7:0] cmd_operand,
    output logic [3:0] alu_inst,
    output logic [7:0] alu_a,
    output logic [7:0] alu_b,
    input  logic [8:0] alu_ans,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [7:0] res_data,
    output logic       res_carry,
    output logic       res_err,
    output logic       busy
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam int                 c_PTR_W    = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [c_PTR_W-1:0] c_PTR_ONE  = c_PTR_W'(1);
    localparam logic [c_PTR_W:0]   c_CNT_ONE  = (c_PTR_W + 1)'(1);
    localparam logic [c_PTR_W:0]   c_CNT_FULL = (c_PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [3:0]         c_OP_NOP   = 4'd8;
    localparam logic [3:0]         c_OP_CLR   = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2,
        S_HOLD = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------------
    state_t             r_state;
    state_t             w_state_nxt;

    logic [11:0]        r_mem [FIFO_DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_PTR_W:0]   r_count;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    logic [3:0]         r_op;
    logic [7:0]         r_operand;
    logic [8:0]         r_ans;
    logic [7:0]         r_acc;
    logic               r_carry;
    logic [7:0]         r_res_data;
    logic               r_res_carry;
    logic               r_res_err;

    logic [7:0]         w_acc_nxt;
    logic               w_carry_nxt;
    logic               w_err_nxt;

    // ------------------------------------------------------------------------
    // FIFO status and handshakes
    // ------------------------------------------------------------------------
    assign w_full  = (r_count == c_CNT_FULL);
    assign w_empty = (r_count == '0);

    // A full FIFO refuses a push even if a pop happens in the same cycle.
    assign cmd_ready = !w_full && !reset;
    assign w_push    = cmd_valid && cmd_ready;
    assign w_pop     = (r_state == S_IDLE) && !w_empty;

    // Command storage. Stale contents are harmless because the pointers and
    // the count define which entries are valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {cmd_op, cmd_operand};
        end
    end

    // FIFO pointers and occupancy. Pointers wrap naturally because the depth
    // is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_ONE;
                2'b01:   r_count <= r_count - c_CNT_ONE;
                default: r_count <= r_count;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Sequencer FSM
    // ------------------------------------------------------------------------
    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: each command visits every state once, so a stream of
    // commands with the consumer always ready retires one every four cycles.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    w_state_nxt = S_EXEC;
                end
            end
            S_EXEC:  w_state_nxt = S_WB;
            S_WB:    w_state_nxt = S_HOLD;
            S_HOLD: begin
                if (res_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------------
    // Result computation
    // ------------------------------------------------------------------------
    // Decide the new accumulator and flags from the opcode and the captured
    // ALU answer. A nop, or an illegal opcode, leaves the architectural state
    // untouched.
    always_comb begin
        w_acc_nxt   = r_acc;
        w_carry_nxt = r_carry;
        w_err_nxt   = 1'b0;
        case (r_op)
            c_OP_NOP: begin
                w_acc_nxt   = r_acc;
                w_carry_nxt = r_carry;
            end
            c_OP_CLR: begin
                w_acc_nxt   = 8'h00;
                w_carry_nxt = 1'b0;
            end
            4'd13, 4'd14, 4'd15: begin
                w_err_nxt = 1'b1;
            end
            default: begin
                w_acc_nxt   = r_ans[7:0];
                w_carry_nxt = r_ans[8];
            end
        endcase
    end

    // Datapath registers. The ALU answer is latched at the end of EXEC,
    // because the ALU inputs return to their idle values in WB.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op        <= 4'd0;
            r_operand   <= 8'h00;
            r_ans       <= 9'h000;
            r_acc       <= 8'h00;
            r_carry     <= 1'b0;
            r_res_data  <= 8'h00;
            r_res_carry <= 1'b0;
            r_res_err   <= 1'b0;
        end else begin
            if (w_pop) begin
                {r_op, r_operand} <= r_mem[r_rd_ptr];
            end
            if (r_state == S_EXEC) begin
                r_ans <= alu_ans;
            end
            if (r_state == S_WB) begin
                r_acc       <= w_acc_nxt;
                r_carry     <= w_carry_nxt;
                r_res_data  <= w_acc_nxt;
                r_res_carry <= w_carry_nxt;
                r_res_err   <= w_err_nxt;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    // ALU drive: the real command is presented only in EXEC. In every other
    // state the ALU sees a nop with a zero B operand.
    always_comb begin
        alu_inst = c_OP_NOP;
        alu_a    = r_acc;
        alu_b    = 8'h00;
        if (r_state == S_EXEC) begin
            alu_inst = r_op;
            alu_b    = r_operand;
        end
    end

    // The result registers change only in WB, so they are stable in HOLD.
    assign res_valid = (r_state == S_HOLD);
    assign res_data  = r_res_data;
    assign res_carry = r_res_carry;
    assign res_err   = r_res_err;
    assign busy      = (r_state != S_IDLE) || !w_empty;

endmodule
`default_nettype wire

// File: tb/tb_alu_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_sequencer
// Description : Self-checking bench for alu_sequencer. It models the external
//               ALU and keeps a reference model of the command stream, which
//               it uses to check every result.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_sequencer;

    localparam int DEPTH = 4;

    logic       clk         = 1'b0;
    logic       reset       = 1'b1;
    logic       cmd_valid   = 1'b0;
    logic [3:0] cmd_op      = 4'd0;
    logic [7:0] cmd_operand = 8'h00;
    logic       res_ready   = 1'b1;
    logic       rr_fixed    = 1'b1;
    logic       rr_rand     = 1'b0;
    logic       cmd_ready;
    logic [3:0] alu_inst;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [8:0] alu_ans;
    logic       res_valid;
    logic [7:0] res_data;
    logic       res_carry;
    logic       res_err;
    logic       busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_res = 0;
    int n_cyc = 0;
    int last_hs = 0;
    int gap = 0;
    logic [7:0] last_d;
    logic       last_c;
    logic       last_e;

    typedef struct packed {
        logic [7:0] d;
        logic       c;
        logic       e;
    } res_t;

    res_t       exp_q[$];
    logic [7:0] m_acc   = 8'h00;
    logic       m_carry = 1'b0;

    always #5 clk = ~clk;

    alu_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_operand(cmd_operand),
        .alu_inst(alu_inst), .alu_a(alu_a), .alu_b(alu_b), .alu_ans(alu_ans),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_carry(res_carry), .res_err(res_err),
        .busy(busy)
    );

    // External ALU. Opcodes 8, 9 and 13-15 return a junk value that the
    // sequencer must ignore.
    function automatic logic [8:0] alu_fn(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        case (op)
            4'd0:    return {1'b0, b};
            4'd1:    return {1'b0, a & b};
            4'd2:    return {1'b0, a} + {1'b0, b};
            4'd3:    return {1'b0, a} - {1'b0, b};
            4'd4:    return {1'b0, a | b};
            4'd5:    return {1'b0, a ^ b};
            4'd6:    return {a, 1'b0};
            4'd7:    return {a[0], 1'b0, a[7:1]};
            4'd10:   return {1'b0, a} + 9'd1;
            4'd11:   return {1'b0, ~b};
            4'd12:   return {1'b0, a} - 9'd1;
            default: return 9'h1A5;
        endcase
    endfunction

    assign alu_ans = alu_fn(alu_inst, alu_a, alu_b);

    // Consumer ready: either a fixed level or random backpressure.
    always @(posedge clk) begin
        #2;
        res_ready = rr_rand ? ($urandom_range(0, 3) != 0) : rr_fixed;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Monitor and reference model. Results are predicted at acceptance time
    // from the stream order, then matched against each result handshake.
    always @(negedge clk) begin
        res_t e;
        logic [8:0] r;
        n_cyc++;
        if (reset) begin
            m_acc   = 8'h00;
            m_carry = 1'b0;
            exp_q.delete();
        end else begin
            if (res_valid && res_ready) begin
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_result", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("res_data", res_data, e.d);
                    check_eq("res_carry", res_carry, e.c);
                    check_eq("res_err", res_err, e.e);
                end
                last_d  = res_data;
                last_c  = res_carry;
                last_e  = res_err;
                gap     = n_cyc - last_hs;
                last_hs = n_cyc;
                n_res++;
            end
            if (cmd_valid && cmd_ready) begin
                e.e = 1'b0;
                if (cmd_op == 4'd9) begin
                    m_acc   = 8'h00;
                    m_carry = 1'b0;
                end else if (cmd_op >= 4'd13) begin
                    e.e = 1'b1;
                end else if (cmd_op != 4'd8) begin
                    r       = alu_fn(cmd_op, m_acc, cmd_operand);
                    m_acc   = r[7:0];
                    m_carry = r[8];
                end
                e.d = m_acc;
                e.c = m_carry;
                exp_q.push_back(e);
            end
        end
    end

    task automatic send(input logic [3:0] op, input logic [7:0] opd);
        bit ok = 0;
        cmd_op      = op;
        cmd_operand = opd;
        cmd_valid   = 1'b1;
        for (int k = 0; k < 200; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_eq("send_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_res(input int target);
        bit ok = 0;
        for (int k = 0; k < 400; k++) begin
            if (n_res >= target) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_eq("result_timeout", n_res, target);
    endtask

    task automatic wait_idle();
        bit ok = 0;
        for (int k = 0; k < 3000; k++) begin
            if (!busy && !res_valid && exp_q.size() == 0) begin
                ok = 1;
                break;
            end
            @(posedge clk); #1;
        end
        if (!ok) check_eq("idle_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #5_000_000;
        n_err++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        int accepted;
        int base;
        bit ok;

        // Reset behaviour
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst_res_valid", res_valid, 1'b0);
        check_eq("rst_res_data", res_data, 8'h00);
        check_eq("rst_res_carry", res_carry, 1'b0);
        check_eq("rst_res_err", res_err, 1'b0);
        check_eq("rst_alu_inst", alu_inst, 4'b1000);
        check_eq("rst_alu_a", alu_a, 8'h00);
        check_eq("rst_alu_b", alu_b, 8'h00);
        check_eq("rst_busy", busy, 1'b0);
        check_eq("post_rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;

        // Minimum latency: clear command into an idle, empty sequencer
        cmd_op      = 4'd9;
        cmd_operand = 8'($urandom);
        cmd_valid   = 1'b1;
        @(negedge clk);
        check_eq("lat_cmd_ready", cmd_ready, 1'b1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        lat = 1;
        while (lat < 20) begin
            @(negedge clk);
            if (res_valid) break;
            @(posedge clk); #1;
            lat++;
        end
        check_eq("latency", lat, 4);
        @(posedge clk); #1;
        wait_res(1);
        check_eq("clr_data", last_d, 8'h00);
        check_eq("clr_carry", last_c, 1'b0);

        send(4'd0, 8'h5A); wait_res(2);
        check_eq("ld_data", last_d, 8'h5A);
        check_eq("ld_carry", last_c, 1'b0);
        send(4'd2, 8'hB0); wait_res(3);
        check_eq("add_data", last_d, 8'h0A);
        check_eq("add_carry", last_c, 1'b1);

        // Subtract with borrow, then complement of B
        send(4'd0, 8'h10);
        send(4'd3, 8'h20); wait_res(5);
        check_eq("sub_data", last_d, 8'hF0);
        check_eq("sub_carry", last_c, 1'b1);
        send(4'd11, 8'h3C); wait_res(6);
        check_eq("not_data", last_d, 8'hC3);

        // Illegal opcode, then nop
        send(4'd0, 8'h77);
        send(4'd14, 8'h05); wait_res(8);
        check_eq("ill_err", last_e, 1'b1);
        check_eq("ill_data", last_d, 8'h77);
        send(4'd8, 8'hFF); wait_res(9);
        check_eq("nop_err", last_e, 1'b0);
        check_eq("nop_data", last_d, 8'h77);

        // Throughput with the consumer always ready
        send(4'd10, 8'h00);
        send(4'd10, 8'h00);
        send(4'd10, 8'h00);
        wait_res(12);
        check_eq("throughput_gap", gap, 4);

        // Backpressure: FIFO fills behind a held result
        wait_idle();
        rr_fixed = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        accepted = 0;
        for (int i = 0; i < 20; i++) begin
            cmd_op      = 4'($urandom_range(0, 12));
            cmd_operand = 8'($urandom);
            cmd_valid   = 1'b1;
            @(negedge clk);
            if (cmd_ready) accepted++;
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        check_eq("bp_accepted", accepted, DEPTH + 1);
        @(negedge clk);
        check_eq("bp_cmd_ready", cmd_ready, 1'b0);
        check_eq("bp_res_valid", res_valid, 1'b1);
        check_eq("bp_busy", busy, 1'b1);
        @(posedge clk); #1;
        // Release with a command still offered: the push can only land after a pop frees a slot
        rr_fixed    = 1'b1;
        cmd_op      = 4'd2;
        cmd_operand = 8'h11;
        cmd_valid   = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        cmd_valid = 1'b0;
        wait_idle();

        // Reset while holding a result with two more commands queued
        rr_fixed = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        send(4'd0, 8'($urandom));
        send(4'd2, 8'($urandom));
        send(4'd5, 8'($urandom));
        ok = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (res_valid) begin
                ok = 1;
                break;
            end
        end
        check_eq("hold_reached", ok, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check_eq("rst2_cmd_ready", cmd_ready, 1'b0);
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        check_eq("rst2_res_valid", res_valid, 1'b0);
        check_eq("rst2_busy", busy, 1'b0);
        check_eq("rst2_acc", alu_a, 8'h00);
        check_eq("rst2_res_data", res_data, 8'h00);
        @(posedge clk); #1;
        rr_fixed = 1'b1;
        base = n_res;
        repeat (20) begin @(posedge clk); #1; end
        check_eq("rst2_no_stale", n_res, base);
        send(4'd4, 8'h3C); wait_res(base + 1);
        check_eq("rst2_after_data", last_d, 8'h3C);

        // Random stream with random consumer backpressure
        rr_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end else begin
                send(4'($urandom_range(0, 15)), 8'($urandom));
            end
        end
        rr_rand = 1'b0;
        wait_idle();
        check_eq("final_queue_empty", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
